johnson_seq_ctrl: RTL and testbench

Run controller for an embedded WIDTH-stage Johnson (twisted-ring) counter with 2*WIDTH states.
- Accepts start/run-length commands and advances the ring exactly N steps, forward or reverse, with hold and abort.
- Provides the binary phase index and pulses done and wrap.
- Sits between a command/sequencing master and the logic that consumes the Johnson phase (timing slots, strobe generation).

---
 rtl/johnson_seq_ctrl_if.sv | 42 ++++
 rtl/johnson_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/johnson_seq_ctrl_if.sv
// Command/status bundle for johnson_seq_ctrl.
// Master drives start/run_len/dir/hold/abort/clear; slave returns count/phase/busy/done/wrap.
interface johnson_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int PH_W  = 4
);
  logic             start;
  logic [CNT_W-1:0] run_len;
  logic             dir;
  logic             hold;
  logic             abort;
  logic             clear;
`ifdef JSC_STOP_AT_PHASE_EN
  logic [PH_W-1:0]  stop_phase;
`endif
  logic [WIDTH-1:0] count;
  logic [PH_W-1:0]  phase;
  logic             busy;
  logic             done;
  logic             wrap;

  modport master (
    output start, run_len, dir,
    output hold, abort, clear,
`ifdef JSC_STOP_AT_PHASE_EN
    output stop_phase,
`endif
    input  count, phase, busy,
    input  done, wrap
  );

  modport slave (
    input  start, run_len, dir,
    input  hold, abort, clear,
`ifdef JSC_STOP_AT_PHASE_EN
    input  stop_phase,
`endif
    output count, phase, busy,
    output done, wrap
  );
endinterface

// File: rtl/johnson_seq_ctrl.sv
// Johnson ring run controller: runs N forward/reverse steps with hold/abort.
// Ports: clk, reset (async, active-high), bus (slave: command in, count/phase/busy/done/wrap out).
// Optional macro JSC_STOP_AT_PHASE_EN adds bus.stop_phase early-termination.
module johnson_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int PH_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  johnson_seq_ctrl_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] nxt;
  logic             stop_hit;
`ifdef JSC_STOP_AT_PHASE_EN
  logic [PH_W-1:0]  stop_q, stop_d;
`endif

  function automatic logic [WIDTH-1:0] fwd(
    input logic [WIDTH-1:0] c
  );
    return {~c[0], c[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] rev(
    input logic [WIDTH-1:0] c
  );
    return {c[WIDTH-2:0], ~c[WIDTH-1]};
  endfunction

  // Top bit set means we are in the filling half
  // of the ring; otherwise the draining half.
  function automatic logic [PH_W-1:0] phase_of(
    input logic [WIDTH-1:0] c
  );
    int p;
    p = 0;
    for (int i = 0; i < WIDTH; i++)
      p += int'(c[i]);
    if (c == '0 || c[WIDTH-1])
      return PH_W'(p);
    return PH_W'(2 * WIDTH - p);
  endfunction

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
`ifdef JSC_STOP_AT_PHASE_EN
    stop_d   = stop_q;
`endif
    nxt = dir_q ? rev(count_q) : fwd(count_q);
`ifdef JSC_STOP_AT_PHASE_EN
    stop_hit = (int'(stop_q) < 2 * WIDTH) &&
               (phase_of(nxt) == stop_q);
`else
    stop_hit = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.clear)
          count_d = '0;
        if (bus.start && !bus.abort) begin
          if (bus.run_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = bus.run_len;
            dir_d   = bus.dir;
`ifdef JSC_STOP_AT_PHASE_EN
            stop_d  = bus.stop_phase;
`endif
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (!bus.hold) begin
          count_d = nxt;
          rem_d   = rem_q - CNT_W'(1);
          wrap_d  = (nxt == '0);
          if (rem_q == CNT_W'(1) || stop_hit) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef JSC_STOP_AT_PHASE_EN
      stop_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
`ifdef JSC_STOP_AT_PHASE_EN
      stop_q  <= stop_d;
`endif
    end
  end

  assign bus.count = count_q;
  assign bus.phase = phase_of(count_q);
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed vector bench for johnson_seq_ctrl.
// Table of {inputs, expected outputs} plus hand sequences for reset/stop.
module tb_johnson_seq_ctrl;

`ifdef JSC_STOP_AT_PHASE_EN
  localparam int PH_W = 5;
`else
  localparam int PH_W = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  johnson_seq_ctrl_if #(
    .WIDTH(8), .CNT_W(8), .PH_W(PH_W)
  ) bus ();

  johnson_seq_ctrl #(
    .WIDTH(8), .CNT_W(8), .PH_W(PH_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic            start;
    logic [7:0]      len;
    logic            dir;
    logic            hold;
    logic            abort;
    logic            clear;
    logic [7:0]      cnt;
    logic [PH_W-1:0] ph;
    logic            busy;
    logic            done;
    logic            wrap;
  } vec_t;

  vec_t v[$];

  function automatic void add(
    int s, int l, int d, int h, int a, int c,
    int cn, int p, int b, int dn, int w
  );
    vec_t e;
    e.start = s[0];
    e.len   = 8'(l);
    e.dir   = d[0];
    e.hold  = h[0];
    e.abort = a[0];
    e.clear = c[0];
    e.cnt   = 8'(cn);
    e.ph    = PH_W'(p);
    e.busy  = b[0];
    e.done  = dn[0];
    e.wrap  = w[0];
    v.push_back(e);
  endfunction

  task automatic chk(
    string nm, logic [31:0] got, logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.count, bus.phase,
                bus.busy, bus.done, bus.wrap});
  endfunction

  task automatic idle_in();
    bus.start   = 1'b0;
    bus.run_len = 8'd0;
    bus.dir     = 1'b0;
    bus.hold    = 1'b0;
    bus.abort   = 1'b0;
    bus.clear   = 1'b0;
`ifdef JSC_STOP_AT_PHASE_EN
    bus.stop_phase = PH_W'(31);
`endif
  endtask

  initial begin
    idle_in();
    #2 reset = 1'b1;
    #1;
    chk("reset_state", outs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Forward 16-step full loop from 0.
    add(1,16,0,0,0,0, 8'h00, 0,1,0,0);
    add(0,0,0,0,0,0, 8'h80, 1,1,0,0);
    add(0,0,0,0,0,0, 8'hC0, 2,1,0,0);
    add(0,0,0,0,0,0, 8'hE0, 3,1,0,0);
    add(0,0,0,0,0,0, 8'hF0, 4,1,0,0);
    add(0,0,0,0,0,0, 8'hF8, 5,1,0,0);
    add(0,0,0,0,0,0, 8'hFC, 6,1,0,0);
    add(0,0,0,0,0,0, 8'hFE, 7,1,0,0);
    add(0,0,0,0,0,0, 8'hFF, 8,1,0,0);
    add(0,0,0,0,0,0, 8'h7F, 9,1,0,0);
    add(0,0,0,0,0,0, 8'h3F,10,1,0,0);
    add(0,0,0,0,0,0, 8'h1F,11,1,0,0);
    add(0,0,0,0,0,0, 8'h0F,12,1,0,0);
    add(0,0,0,0,0,0, 8'h07,13,1,0,0);
    add(0,0,0,0,0,0, 8'h03,14,1,0,0);
    add(0,0,0,0,0,0, 8'h01,15,1,0,0);
    add(0,0,0,0,0,0, 8'h00, 0,0,1,1);
    // Reverse 3.
    add(1,3,1,0,0,0, 8'h00, 0,1,0,0);
    add(0,0,0,0,0,0, 8'h01,15,1,0,0);
    add(0,0,0,0,0,0, 8'h03,14,1,0,0);
    add(0,0,0,0,0,0, 8'h07,13,0,1,0);
    add(0,0,0,0,0,0, 8'h07,13,0,0,0);
    // Clear, then hold for 4; start/clear while busy ignored.
    add(0,0,0,0,0,1, 8'h00, 0,0,0,0);
    add(1,5,0,0,0,0, 8'h00, 0,1,0,0);
    add(0,0,0,0,0,0, 8'h80, 1,1,0,0);
    add(0,0,0,0,0,0, 8'hC0, 2,1,0,0);
    add(1,1,0,1,0,0, 8'hC0, 2,1,0,0);
    add(0,0,0,1,0,1, 8'hC0, 2,1,0,0);
    add(0,0,0,1,0,0, 8'hC0, 2,1,0,0);
    add(0,0,0,1,0,0, 8'hC0, 2,1,0,0);
    add(0,0,0,0,0,1, 8'hE0, 3,1,0,0);
    add(1,1,0,0,0,0, 8'hF0, 4,1,0,0);
    add(0,0,0,0,0,0, 8'hF8, 5,0,1,0);
    add(0,0,0,0,0,0, 8'hF8, 5,0,0,0);
    // Clear+start, abort (overrides hold), len 0, abort blocks start.
    add(1,10,0,0,0,1, 8'h00, 0,1,0,0);
    add(0,0,0,0,0,0, 8'h80, 1,1,0,0);
    add(0,0,0,0,0,0, 8'hC0, 2,1,0,0);
    add(0,0,0,0,0,0, 8'hE0, 3,1,0,0);
    add(0,0,0,0,0,0, 8'hF0, 4,1,0,0);
    add(0,0,0,1,1,0, 8'hF0, 4,0,0,0);
    add(0,0,0,0,0,0, 8'hF0, 4,0,0,0);
    add(1,0,0,0,0,0, 8'hF0, 4,0,1,0);
    add(0,0,0,0,0,0, 8'hF0, 4,0,0,0);
    add(1,3,0,0,1,0, 8'hF0, 4,0,0,0);
    add(0,0,0,0,0,0, 8'hF0, 4,0,0,0);
    // Reverse into 0: wrap coincides with done.
    add(1,4,1,0,0,0, 8'hF0, 4,1,0,0);
    add(0,0,0,0,0,0, 8'hE0, 3,1,0,0);
    add(0,0,0,0,0,0, 8'hC0, 2,1,0,0);
    add(0,0,0,0,0,0, 8'h80, 1,1,0,0);
    add(0,0,0,0,0,0, 8'h00, 0,0,1,1);
    add(1,1,1,0,0,0, 8'h00, 0,1,0,0);
    add(0,0,0,0,0,0, 8'h01,15,0,1,0);
    // Mid-run wrap without done.
    add(1,3,0,0,0,0, 8'h01,15,1,0,0);
    add(0,0,0,0,0,0, 8'h00, 0,1,0,1);
    add(0,0,0,0,0,0, 8'h80, 1,1,0,0);
    add(0,0,0,0,0,0, 8'hC0, 2,0,1,0);
    add(0,0,0,0,0,0, 8'hC0, 2,0,0,0);

    foreach (v[i]) begin
      bus.start   = v[i].start;
      bus.run_len = v[i].len;
      bus.dir     = v[i].dir;
      bus.hold    = v[i].hold;
      bus.abort   = v[i].abort;
      bus.clear   = v[i].clear;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs(),
          32'({v[i].cnt, v[i].ph, v[i].busy,
               v[i].done, v[i].wrap}));
    end

    // Async reset mid-run at FE; start mid-run ignored.
    idle_in();
    bus.clear   = 1'b1;
    bus.start   = 1'b1;
    bus.run_len = 8'd10;
    @(posedge clk);
    @(negedge clk);
    idle_in();
    for (int k = 0; k < 7; k++) begin
      bus.start   = (k == 2);
      bus.run_len = (k == 2) ? 8'd1 : 8'd0;
      @(posedge clk);
      @(negedge clk);
    end
    idle_in();
    chk("pre_reset_cnt", 32'(bus.count), 32'h00FE);
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", 32'(bus.count), 32'd0);
    chk("async_rst_st", outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post_reset", outs(), 32'd0);

`ifdef JSC_STOP_AT_PHASE_EN
    bus.start      = 1'b1;
    bus.run_len    = 8'd20;
    bus.stop_phase = PH_W'(9);
    @(posedge clk);
    @(negedge clk);
    idle_in();
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("stop_phase", outs(),
        32'({8'h7F, PH_W'(9), 1'b0, 1'b1, 1'b0}));
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
